bitwise_burst_accumulator: RTL and testbench
============================================

Name: bitwise_burst_accumulator

Overview:
- Parametrised sequential successor to the 16-bit two-input OR gate.
- Folds a burst of WIDTH-bit words into one word, one beat per clock.
- Op per burst: OR, AND, XOR or NAND.
- Sits between a word producer (register file / memory read stream) and a consumer; valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, data width in bits (≥1).
- MAX_BEATS, 8, maximum words per burst (≥1); the burst force-closes at this count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; single clock domain.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  WIDTH  data word.
- in_last  input  1  final word of burst, qualified by in_valid.
- op  input  2  00=OR, 01=AND, 10=XOR, 11=NAND; sampled on the first beat only.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_data  output  WIDTH  folded result.
- out_count  output  $clog2(MAX_BEATS+1)  beats folded into out_data.
- out_trunc  output  1  burst closed by MAX_BEATS without in_last.

Behaviour:
- Beat accepted = in_valid & in_ready at a rising edge. Result taken = out_valid & out_ready.
- Reset: synchronous and has priority over everything.
  - State→IDLE; acc=0; count=0; op_q=00; trunc=0.
  - out_valid=0, out_data=0, out_count=0, out_trunc=0.
  - in_ready=0 in any cycle where reset=1.
  - Reset mid-burst or in DONE discards the partial or pending result.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a beat: acc←in_data, op_q←op, count←1.
  - Next state is DONE if in_last or MAX_BEATS=1, else ACCUM.
- ACCUM:
  - in_ready=1, out_valid=0; the op input is ignored.
  - On a beat: acc←acc OP in_data, count←count+1. NAND accumulates as AND.
  - Next state is DONE if in_last or count+1==MAX_BEATS; trunc←(count+1==MAX_BEATS)&~in_last.
  - No beat: hold all state; bubbles are allowed.
- DONE:
  - in_ready=0, out_valid=1.
  - out_data=acc, or ~acc when op_q=11; out_count=count; out_trunc=trunc.
  - Outputs stay stable until taken.
  - On result taken: go to IDLE, clear trunc. acc and count hold but are not visible.
- Outputs in IDLE/ACCUM: out_data=0, out_count=0, out_trunc=0.
- Latency: out_valid rises the cycle after the last beat is accepted.
  - Minimum burst period is N+1 cycles when out_ready is held at 1.
  - The first beat of the next burst is accepted the cycle after the result is taken.
- All arithmetic is bitwise across WIDTH; no carries. The count never exceeds MAX_BEATS.
- in_last arriving together with the MAX_BEATS-th beat: DONE with trunc=0.
- in_data, in_last and op are don't-care when in_valid=0.

Optional Feature:
- Macro: BITWISE_BURST_ACCUMULATOR_ZERO_FLAG_EN.
- Defined: adds output out_zero (1 bit).
  - out_zero = out_valid & (out_data == 0).
  - It is 0 at reset and whenever out_valid=0.
- Undefined: the out_zero port does not exist; all other behaviour is identical.

Test Plan:
- OR, WIDTH=16, with out_ready=1:
  - Stimulus: op=00, beats 0x5555, 0xCCCC, then 0x0505 with last.
  - Required: out_data=0xDDDD, out_count=3, out_trunc=0.
  - out_valid is high for exactly one cycle, the cycle after the third beat.
- AND then NAND, back-to-back:
  - Burst 1: op=01, beats 0x85DD, 0xFFFF with last → 0x85DD, count 2.
  - Burst 2: op=11, single beat 0x0F0F with last → 0xF0F0, count 1.
  - Required: in_ready=0 during each DONE cycle.
- XOR with bubbles and backpressure:
  - Stimulus: op=10, beats 0x1234, idle, idle, 0x1234 with last; out_ready=0 for 3 cycles.
  - Required: out_data=0x0000 held stable with out_valid=1 for 4 cycles; zero flag=1 when the macro is defined.
- Truncation, MAX_BEATS=8:
  - Stimulus: op=00, 9 beats of 0x0001<<i, no last.
  - Required: closes after 8 beats; out_data=0x00FF, out_count=8, out_trunc=1.
  - The 9th word is not accepted until after the result is taken.
- Mid-burst reset:
  - Stimulus: reset=1 for one cycle after 2 beats of a burst; then a fresh OR burst 0x00F0 with last.
  - Required: in_ready=0 during reset; out_data=0x00F0, count 1; no stale data.
- Op latch:
  - Stimulus: op=00 on beat 1 (0x0F00), op changed to 01 on beat 2 (0x00F0 with last).
  - Required: out_data=0x0FF0.

Source files
------------

// File: rtl/bitwise_burst_accumulator.sv
// bitwise_burst_accumulator
//   Purpose : folds a burst of WIDTH-bit words into one word with OR, AND,
//             XOR or NAND. The op is chosen on the first beat of each burst.
//   Latency : out_valid rises the cycle after the last beat is accepted.
//             The minimum burst period is N+1 cycles.
//   Backpressure: in_ready is low while a result is pending, so the next
//             burst waits until out_ready takes the result. in_ready is also
//             low in any cycle where reset is high.
// Ports:
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data     word stream from the producer
//   in_last                       final word of the burst
//   op                            00=OR 01=AND 10=XOR 11=NAND, sampled on the first beat
//   out_valid/out_ready/out_data  folded result to the consumer
//   out_count                     number of beats folded into out_data
//   out_trunc                     burst closed at MAX_BEATS without in_last
//   out_zero                      out_valid & (out_data == 0); present only when
//                                 BITWISE_BURST_ACCUMULATOR_ZERO_FLAG_EN is defined
module bitwise_burst_accumulator #(
  parameter  int WIDTH     = 16,
  parameter  int MAX_BEATS = 8,
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_trunc
`ifdef BITWISE_BURST_ACCUMULATOR_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic             trunc_q, trunc_d;

  logic             beat;
  logic             taken;
  logic [CW-1:0]    count_inc;
  logic             hit_max;
  logic [WIDTH-1:0] fold;

  assign in_ready  = ~reset & (state_q != S_DONE);
  assign out_valid = (state_q == S_DONE);
  assign beat      = in_valid & in_ready;
  assign taken     = out_valid & out_ready;
  assign count_inc = count_q + CW'(1);
  assign hit_max   = (count_inc == CW'(MAX_BEATS));

  // NAND folds as AND. The inversion is applied only when the result is presented.
  always_comb begin
    fold = acc_q | in_data;
    case (op_q)
      OP_OR:   fold = acc_q | in_data;
      OP_AND:  fold = acc_q & in_data;
      OP_XOR:  fold = acc_q ^ in_data;
      OP_NAND: fold = acc_q & in_data;
      default: fold = acc_q | in_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    op_d    = op_q;
    trunc_d = trunc_q;
    case (state_q)
      S_IDLE: begin
        if (beat) begin
          acc_d   = in_data;
          op_d    = op;
          count_d = CW'(1);
          // A one-beat limit closes the burst on its first word.
          trunc_d = (MAX_BEATS == 1) & ~in_last;
          state_d = (in_last || MAX_BEATS == 1) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (beat) begin
          acc_d   = fold;
          count_d = count_inc;
          trunc_d = hit_max & ~in_last;
          if (in_last || hit_max) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (taken) begin
          state_d = S_IDLE;
          trunc_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      op_q    <= OP_OR;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      op_q    <= op_d;
      trunc_q <= trunc_d;
    end
  end

  // The accumulator and count stay hidden outside DONE.
  assign out_data  = out_valid ? ((op_q == OP_NAND) ? ~acc_q : acc_q) : '0;
  assign out_count = out_valid ? count_q : '0;
  assign out_trunc = out_valid & trunc_q;

`ifdef BITWISE_BURST_ACCUMULATOR_ZERO_FLAG_EN
  assign out_zero = out_valid & (out_data == '0);
`endif

endmodule

// File: tb/tb_bitwise_burst_accumulator.sv
module tb_bitwise_burst_accumulator;

  localparam int W  = 16;
  localparam int MB = 8;
  localparam int CW = $clog2(MB + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic [1:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_trunc;
`ifdef BITWISE_BURST_ACCUMULATOR_ZERO_FLAG_EN
  logic          out_zero;
`endif

  bitwise_burst_accumulator #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_trunc(out_trunc)
`ifdef BITWISE_BURST_ACCUMULATOR_ZERO_FLAG_EN
    , .out_zero(out_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [CW-1:0] count;
    logic          trunc;
  } res_t;

  typedef struct {
    logic [1:0]    op_first;
    logic [1:0]    op_later;
    int            n;
    logic          last;
    logic [W-1:0]  beats [MB];
    logic [W-1:0]  exp_data;
    logic [CW-1:0] exp_count;
    logic          exp_trunc;
  } vec_t;

  res_t exp_q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each taken result is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      check("in_ready_low_in_done", {31'b0, in_ready}, 32'd0);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          res_t r;
          r = exp_q.pop_front();
          check("out_data", {16'b0, out_data}, {16'b0, r.data});
          check("out_count", {28'b0, out_count}, {28'b0, r.count});
          check("out_trunc", {31'b0, out_trunc}, {31'b0, r.trunc});
`ifdef BITWISE_BURST_ACCUMULATOR_ZERO_FLAG_EN
          check("out_zero", {31'b0, out_zero}, {31'b0, (r.data == '0)});
`endif
        end
      end
    end
  end

  task automatic expect_res(input logic [W-1:0] d, input logic [CW-1:0] c, input logic t);
    res_t r;
    r.data = d; r.count = c; r.trunc = t;
    exp_q.push_back(r);
  endtask

  // Present one beat and return at posedge+1 of the edge that accepted it.
  task automatic drive_beat(input logic [W-1:0] d, input logic l, input logic [1:0] o);
    int t;
    in_valid = 1'b1; in_data = d; in_last = l; op = o;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      t++;
      if (t > 100) begin
        check("beat_accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = $urandom; op = 2'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      check("result_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic add_vec(input logic [1:0] o1, input logic [1:0] o2, input int n, input logic l,
                         input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2,
                         input logic shift, input logic [W-1:0] ed, input logic [CW-1:0] ec,
                         input logic et);
    vec_t v;
    v.op_first = o1; v.op_later = o2; v.n = n; v.last = l;
    for (int i = 0; i < MB; i++) v.beats[i] = shift ? (W'(1) << i) : '0;
    if (!shift) begin
      v.beats[0] = w0; v.beats[1] = w1; v.beats[2] = w2;
    end
    v.exp_data = ed; v.exp_count = ec; v.exp_trunc = et;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; op = 2'b00; out_ready = 1'b1;

    // op, op on later beats, beats, last, words, shift pattern, expected data/count/trunc
    add_vec(2'b00, 2'b00, 3, 1'b1, 16'h5555, 16'hCCCC, 16'h0505, 1'b0, 16'hDDDD, 4'd3, 1'b0);
    add_vec(2'b01, 2'b01, 2, 1'b1, 16'h85DD, 16'hFFFF, 16'h0000, 1'b0, 16'h85DD, 4'd2, 1'b0);
    add_vec(2'b11, 2'b11, 1, 1'b1, 16'h0F0F, 16'h0000, 16'h0000, 1'b0, 16'hF0F0, 4'd1, 1'b0);
    add_vec(2'b00, 2'b01, 2, 1'b1, 16'h0F00, 16'h00F0, 16'h0000, 1'b0, 16'h0FF0, 4'd2, 1'b0);
    add_vec(2'b10, 2'b00, 3, 1'b1, 16'hA5A5, 16'hFFFF, 16'h0F0F, 1'b0, 16'h5555, 4'd3, 1'b0);
    add_vec(2'b11, 2'b10, 2, 1'b1, 16'hFF00, 16'hF0F0, 16'h0000, 1'b0, 16'h0FFF, 4'd2, 1'b0);
    add_vec(2'b00, 2'b00, 8, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h00FF, 4'd8, 1'b1);
    add_vec(2'b00, 2'b11, 8, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h00FF, 4'd8, 1'b0);
    add_vec(2'b01, 2'b01, 8, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd8, 1'b0);

    // Reset state.
    @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", {16'b0, out_data}, 32'd0);
    check("reset_out_count", {28'b0, out_count}, 32'd0);
    check("reset_out_trunc", {31'b0, out_trunc}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // OR burst: out_valid is high for exactly one cycle, and the next burst
    // is accepted in the cycle after the result is taken.
    expect_res(16'hDDDD, 4'd3, 1'b0);
    drive_beat(16'h5555, 1'b0, 2'b00);
    drive_beat(16'hCCCC, 1'b0, 2'b00);
    drive_beat(16'h0505, 1'b1, 2'b00);
    @(negedge clk);
    check("or_valid_cycle1", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    check("or_valid_cycle2", {31'b0, out_valid}, 32'd0);
    check("or_ready_after", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    drain();

    // Table-driven bursts with the consumer always ready.
    foreach (vecs[k]) begin
      expect_res(vecs[k].exp_data, vecs[k].exp_count, vecs[k].exp_trunc);
      for (int i = 0; i < vecs[k].n; i++)
        drive_beat(vecs[k].beats[i], vecs[k].last && (i == vecs[k].n - 1),
                   (i == 0) ? vecs[k].op_first : vecs[k].op_later);
      drain();
    end

    // XOR with bubbles, then a result held for 4 cycles under backpressure.
    out_ready = 1'b0;
    expect_res(16'h0000, 4'd2, 1'b0);
    drive_beat(16'h1234, 1'b0, 2'b10);
    repeat (2) @(posedge clk);
    #1;
    drive_beat(16'h1234, 1'b1, 2'b01);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("xor_hold_valid", {31'b0, out_valid}, 32'd1);
      check("xor_hold_data", {16'b0, out_data}, 32'd0);
      check("xor_hold_count", {28'b0, out_count}, 32'd2);
`ifdef BITWISE_BURST_ACCUMULATOR_ZERO_FLAG_EN
      check("xor_hold_zero", {31'b0, out_zero}, 32'd1);
`endif
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Truncation: the 9th word waits until the truncated result is taken.
    out_ready = 1'b0;
    expect_res(16'h00FF, 4'd8, 1'b1);
    expect_res(16'h0100, 4'd1, 1'b0);
    for (int i = 0; i < 8; i++) drive_beat(W'(1) << i, 1'b0, 2'b00);
    in_valid = 1'b1; in_data = 16'h0100; in_last = 1'b1; op = 2'b00;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("trunc_ninth_blocked", {31'b0, in_ready}, 32'd0);
      check("trunc_valid", {31'b0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_beat(16'h0100, 1'b1, 2'b00);
    drain();

    // Reset in the middle of a burst discards the partial result.
    drive_beat(16'hAAAA, 1'b0, 2'b00);
    drive_beat(16'h5555, 1'b0, 2'b00);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    check("midreset_out_data", {16'b0, out_data}, 32'd0);
    check("midreset_out_count", {28'b0, out_count}, 32'd0);
    @(posedge clk); #1;
    expect_res(16'h00F0, 4'd1, 1'b0);
    drive_beat(16'h00F0, 1'b1, 2'b00);
    drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
